// File: rtl/snake_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | snake_pkg                                                            |
// | Shared definitions for the snake keyboard front end: heading         |
// | encodings, PS/2 scan-code constants, prefix FSM state encoding and   |
// | a make-code to direction decoder.                                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package snake_pkg;

  // Heading encoding; bit 1 flipped gives the opposite heading.
  typedef logic [1:0] dir_t;
  localparam dir_t DIR_UP    = 2'b00;
  localparam dir_t DIR_RIGHT = 2'b01;
  localparam dir_t DIR_DOWN  = 2'b10;
  localparam dir_t DIR_LEFT  = 2'b11;

  // PS/2 set-2 scan codes
  localparam logic [7:0] SC_EXT         = 8'hE0;
  localparam logic [7:0] SC_BREAK       = 8'hF0;
  localparam logic [7:0] SC_ARROW_UP    = 8'h75;
  localparam logic [7:0] SC_ARROW_RIGHT = 8'h74;
  localparam logic [7:0] SC_ARROW_DOWN  = 8'h72;
  localparam logic [7:0] SC_ARROW_LEFT  = 8'h6B;
  localparam logic [7:0] SC_W           = 8'h1D;
  localparam logic [7:0] SC_D           = 8'h23;
  localparam logic [7:0] SC_S           = 8'h1B;
  localparam logic [7:0] SC_A           = 8'h1C;
  localparam logic [7:0] SC_SPACE       = 8'h29;
  localparam logic [7:0] SC_ESC         = 8'h76;

  // Prefix FSM state encoding
  typedef logic [1:0] pfx_state_t;
  localparam pfx_state_t PFX_IDLE    = 2'd0;
  localparam pfx_state_t PFX_EXT     = 2'd1;
  localparam pfx_state_t PFX_BRK     = 2'd2;
  localparam pfx_state_t PFX_EXT_BRK = 2'd3;

  // Returns {hit, direction}. Arrows only count when E0-prefixed,
  // WASD only when not prefixed.
  function automatic logic [2:0] decode_dir(input logic [7:0] code, input logic ext);
    logic [2:0] r;
    r = 3'b000;
    if (ext) begin
      case (code)
        SC_ARROW_UP:    r = {1'b1, DIR_UP};
        SC_ARROW_RIGHT: r = {1'b1, DIR_RIGHT};
        SC_ARROW_DOWN:  r = {1'b1, DIR_DOWN};
        SC_ARROW_LEFT:  r = {1'b1, DIR_LEFT};
        default:        r = 3'b000;
      endcase
    end else begin
      case (code)
        SC_W:    r = {1'b1, DIR_UP};
        SC_D:    r = {1'b1, DIR_RIGHT};
        SC_S:    r = {1'b1, DIR_DOWN};
        SC_A:    r = {1'b1, DIR_LEFT};
        default: r = 3'b000;
      endcase
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/turn_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | turn_fifo                                                            |
// | Small synchronous FIFO of 2-bit headings. Push and pop may happen in |
// | the same cycle; when full, a simultaneous push+pop both succeed.     |
// | clear has priority over push/pop and empties the queue.              |
// | Ports: clk, reset (sync, active-high), push_i, pop_i, clear_i,       |
// |        din_i, head_o (oldest), tail_o (newest), count_o, full_o,     |
// |        empty_o                                                       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module turn_fifo
  import snake_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     clear_i,
  input  logic [1:0]               din_i,
  output logic [1:0]               head_o,
  output logic [1:0]               tail_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PW = $clog2(DEPTH);

  dir_t              mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [PW:0]       count_q;
  logic              do_push;
  logic              do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  // Newest entry sits one slot behind the write pointer (wraps on power-of-two depth).
  assign tail_o  = mem_q[wr_ptr_q - PW'(1)];

  assign do_pop  = pop_i && !empty_o;
  // When full, a push is only accepted if the head leaves in the same edge.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (do_push && !clear_i && !reset) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/key_dir_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | key_dir_controller                                                   |
// | Turns decoded PS/2 scan-code bytes into snake control: tracks E0/F0  |
// | prefixes, decodes direction/pause/restart make codes, filters turns  |
// | (no repeats, no reversals) into a queue the engine drains per step.  |
// | Ports: clk, reset (sync, active-high), key_valid, key_code[7:0],     |
// |        step, dir[1:0], paused, restart (1-cycle pulse), queue_count  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module key_dir_controller
  import snake_pkg::*;
#(
  parameter int QUEUE_DEPTH    = 2,
  parameter int PREFIX_TIMEOUT = 1_000_000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           key_valid,
  input  logic [7:0]                     key_code,
  input  logic                           step,
  output logic [1:0]                     dir,
  output logic                           paused,
  output logic                           restart,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_count
);

  localparam int CNT_W = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(PREFIX_TIMEOUT - 1);

  pfx_state_t                    state_q, state_d;
  logic [CNT_W-1:0]              tcnt_q, tcnt_d;
  dir_t                          dir_q, dir_d;
  logic                          paused_q, paused_d;
  logic                          restart_q;

  logic                          dec_hit;
  dir_t                          dec_dir;
  logic                          pause_cmd;
  logic                          restart_cmd;

  dir_t                          ref_dir;
  logic                          turn_ok;
  logic                          fifo_push;
  logic                          fifo_pop;
  dir_t                          fifo_head;
  dir_t                          fifo_tail;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic [$clog2(QUEUE_DEPTH):0]  fifo_count;

  // Prefix FSM, timeout counter and make-code decode
  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    dec_hit     = 1'b0;
    dec_dir     = DIR_UP;
    pause_cmd   = 1'b0;
    restart_cmd = 1'b0;

    if (key_valid) begin
      case (state_q)
        PFX_IDLE: begin
          if (key_code == SC_EXT) begin
            state_d = PFX_EXT;
            tcnt_d  = '0;
          end else if (key_code == SC_BREAK) begin
            state_d = PFX_BRK;
            tcnt_d  = '0;
          end else begin
            {dec_hit, dec_dir} = decode_dir(key_code, 1'b0);
            pause_cmd          = (key_code == SC_SPACE);
            restart_cmd        = (key_code == SC_ESC);
          end
        end
        PFX_EXT: begin
          if (key_code == SC_BREAK) begin
            state_d = PFX_EXT_BRK;
            tcnt_d  = '0;
          end else begin
            {dec_hit, dec_dir} = decode_dir(key_code, 1'b1);
            state_d            = PFX_IDLE;
          end
        end
        // Break-code byte: released key, nothing to act on.
        default: state_d = PFX_IDLE;
      endcase
    end else if (state_q != PFX_IDLE) begin
      // Abandon a stranded prefix so a lost byte cannot swallow the next key.
      if (tcnt_q == TIMEOUT_LAST) begin
        state_d = PFX_IDLE;
        tcnt_d  = '0;
      end else begin
        tcnt_d = tcnt_q + CNT_W'(1);
      end
    end

    if (restart_cmd) begin
      state_d = PFX_IDLE;
      tcnt_d  = '0;
    end
  end

  // Turn filter compares against the last heading the snake will have
  // once everything already queued has been applied.
  assign ref_dir   = fifo_empty ? dir_q : fifo_tail;
  assign turn_ok   = dec_hit && (dec_dir != ref_dir) && (dec_dir != (ref_dir ^ 2'b10));
  assign fifo_pop  = step && !fifo_empty && !paused_q && !restart_cmd;
  assign fifo_push = turn_ok && !restart_cmd && (!fifo_full || fifo_pop);

  always_comb begin
    dir_d    = dir_q;
    paused_d = paused_q;
    if (restart_cmd) begin
      dir_d    = DIR_RIGHT;
      paused_d = 1'b0;
    end else begin
      if (fifo_pop)  dir_d    = fifo_head;
      if (pause_cmd) paused_d = ~paused_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= PFX_IDLE;
      tcnt_q    <= '0;
      dir_q     <= DIR_RIGHT;
      paused_q  <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      dir_q     <= dir_d;
      paused_q  <= paused_d;
      restart_q <= restart_cmd;
    end
  end

  turn_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_turn_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .clear_i (restart_cmd),
    .din_i   (dec_dir),
    .head_o  (fifo_head),
    .tail_o  (fifo_tail),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign dir         = dir_q;
  assign paused      = paused_q;
  assign restart     = restart_q;
  assign queue_count = fifo_count;

endmodule
`default_nettype wire

// File: tb/tb_key_dir_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_key_dir_controller                                                |
// | Directed scenarios followed by random byte/step traffic, every cycle |
// | compared against a queue-based behavioural model of the controller.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_key_dir_controller;

  localparam int QD = 2;
  localparam int TO = 16;
  localparam int CW = $clog2(QD) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          key_valid;
  logic [7:0]    key_code;
  logic          step;
  logic [1:0]    dir;
  logic          paused;
  logic          restart;
  logic [CW-1:0] queue_count;

  int passes = 0;
  int fails  = 0;
  int total  = 0;

  // Behavioural model state
  int         m_pfx;   // 0 none, 1 after E0, 2 after F0, 3 after E0 F0
  int         m_wait;  // idle cycles spent in a prefix
  logic [1:0] m_dir;
  bit         m_paused;
  bit         m_restart;
  logic [1:0] m_q[$];

  key_dir_controller #(
    .QUEUE_DEPTH    (QD),
    .PREFIX_TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .step        (step),
    .dir         (dir),
    .paused      (paused),
    .restart     (restart),
    .queue_count (queue_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int dir_of(input logic [7:0] c, input bit ext);
    if (ext) begin
      case (c)
        8'h75: return 0;
        8'h74: return 1;
        8'h72: return 2;
        8'h6B: return 3;
        default: return -1;
      endcase
    end
    case (c)
      8'h1D: return 0;
      8'h23: return 1;
      8'h1B: return 2;
      8'h1C: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic model_init();
    m_pfx = 0; m_wait = 0; m_dir = 2'd1; m_paused = 0; m_restart = 0;
    m_q.delete();
  endtask

  task automatic model_step(input bit kv, input logic [7:0] c, input bit st);
    int  d = -1;
    int  r;
    bit  rs = 0, tog = 0, popit;
    r = (m_q.size() > 0) ? int'(m_q[m_q.size()-1]) : int'(m_dir);
    if (kv) begin
      case (m_pfx)
        0: begin
          if (c == 8'hE0)      begin m_pfx = 1; m_wait = 0; end
          else if (c == 8'hF0) begin m_pfx = 2; m_wait = 0; end
          else begin
            d   = dir_of(c, 0);
            tog = (c == 8'h29);
            rs  = (c == 8'h76);
          end
        end
        1: begin
          if (c == 8'hF0) begin m_pfx = 3; m_wait = 0; end
          else begin d = dir_of(c, 1); m_pfx = 0; end
        end
        default: m_pfx = 0;
      endcase
    end else if (m_pfx != 0) begin
      m_wait++;
      if (m_wait == TO) m_pfx = 0;
    end
    popit = st && !m_paused && (m_q.size() > 0);
    if (rs) begin
      m_q.delete(); m_dir = 2'd1; m_paused = 0; m_pfx = 0;
    end else begin
      if (popit) m_dir = m_q.pop_front();
      if (d >= 0 && d != r && d != (r ^ 2) && m_q.size() < QD) m_q.push_back(2'(d));
      if (tog) m_paused = !m_paused;
    end
    m_restart = rs;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".dir"},    8'(dir),         8'(m_dir));
    chk({tag, ".paused"}, 8'(paused),      8'(m_paused));
    chk({tag, ".restart"},8'(restart),     8'(m_restart));
    chk({tag, ".count"},  8'(queue_count), 8'(m_q.size()));
  endtask

  task automatic cycle(input bit kv, input logic [7:0] c, input bit st);
    key_valid = kv; key_code = c; step = st;
    model_step(kv, c, st);
    @(posedge clk); #1;
    key_valid = 0; step = 0;
    check_model("cyc");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 8'h00, 0);
  endtask

  task automatic do_reset(input bit kv, input logic [7:0] c);
    reset = 1; key_valid = kv; key_code = c; step = 1;
    @(posedge clk); #1;
    reset = 0; key_valid = 0; step = 0;
    model_init();
    chk("rst.dir",     8'(dir),         8'h01);
    chk("rst.paused",  8'(paused),      8'h00);
    chk("rst.restart", 8'(restart),     8'h00);
    chk("rst.count",   8'(queue_count), 8'h00);
  endtask

  initial begin
    reset = 1; key_valid = 0; key_code = 8'h00; step = 0;
    model_init();
    @(posedge clk); #1;
    do_reset(0, 8'h00);

    // Extended up arrow, then step applies it
    cycle(1, 8'hE0, 0); cycle(1, 8'h75, 0);
    chk("ext_up.count", 8'(queue_count), 8'h01);
    cycle(0, 8'h00, 1);
    chk("ext_up.dir", 8'(dir), 8'h00);
    chk("ext_up.count0", 8'(queue_count), 8'h00);

    // Reversal and repeat are rejected
    do_reset(0, 8'h00);
    cycle(1, 8'h1C, 0); cycle(1, 8'h23, 0);
    chk("rev_rep.count", 8'(queue_count), 8'h00);

    // Full queue drops the third turn
    do_reset(0, 8'h00);
    cycle(1, 8'h1D, 0); cycle(1, 8'h1C, 0); cycle(1, 8'h1B, 0);
    chk("full.count", 8'(queue_count), 8'h02);
    cycle(0, 8'h00, 1);
    chk("full.dir1", 8'(dir), 8'h00);
    cycle(0, 8'h00, 1);
    chk("full.dir2", 8'(dir), 8'h03);

    // Break sequences are discarded
    cycle(1, 8'hF0, 0); cycle(1, 8'h1D, 0);
    chk("brk.count", 8'(queue_count), 8'h00);
    cycle(1, 8'hE0, 0); cycle(1, 8'hF0, 0); cycle(1, 8'h75, 0);
    chk("extbrk.count", 8'(queue_count), 8'h00);
    // One cycle short of the timeout: 1D is still read as an extended code
    cycle(1, 8'hE0, 0); idle(TO - 1); cycle(1, 8'h1D, 0);
    chk("to_short.count", 8'(queue_count), 8'h00);
    // Full timeout: back in IDLE, 1D is W (up)
    cycle(1, 8'hE0, 0); idle(TO); cycle(1, 8'h1D, 0);
    chk("to_full.count", 8'(queue_count), 8'h01);

    // Pause blocks step, unpause lets it pop
    cycle(1, 8'h29, 0);
    chk("pause.on", 8'(paused), 8'h01);
    cycle(0, 8'h00, 1);
    chk("pause.dir", 8'(dir), 8'h03);
    chk("pause.count", 8'(queue_count), 8'h01);
    cycle(1, 8'h29, 0);
    chk("pause.off", 8'(paused), 8'h00);
    cycle(0, 8'h00, 1);
    chk("unpause.dir", 8'(dir), 8'h00);

    // Restart together with step wins
    cycle(1, 8'h23, 0); cycle(1, 8'h1B, 0);
    chk("pre_rst.count", 8'(queue_count), 8'h02);
    cycle(1, 8'h76, 1);
    chk("esc.restart", 8'(restart), 8'h01);
    chk("esc.count",   8'(queue_count), 8'h00);
    chk("esc.dir",     8'(dir), 8'h01);
    chk("esc.paused",  8'(paused), 8'h00);
    idle(1);
    chk("esc.pulse_end", 8'(restart), 8'h00);

    // Reset in the middle of a prefix
    cycle(1, 8'hE0, 0);
    do_reset(1, 8'h75);
    cycle(1, 8'h1D, 0);
    chk("midpfx.count", 8'(queue_count), 8'h01);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int  r;
      bit  kv;
      logic [7:0] c;
      r  = int'($urandom_range(0, 99));
      kv = ($urandom_range(0, 99) < 55);
      if (r < 2)       c = 8'h76;
      else if (r < 6)  c = 8'h29;
      else if (r < 20) c = 8'hE0;
      else if (r < 32) c = 8'hF0;
      else if (r < 40) c = 8'($urandom_range(0, 255));
      else begin
        case ($urandom_range(0, 7))
          0: c = 8'h1D; 1: c = 8'h23; 2: c = 8'h1B; 3: c = 8'h1C;
          4: c = 8'h75; 5: c = 8'h74; 6: c = 8'h72; default: c = 8'h6B;
        endcase
      end
      if ($urandom_range(0, 199) == 0) idle(TO + 2);
      if ($urandom_range(0, 499) == 0) do_reset(kv, c);
      else cycle(kv, c, $urandom_range(0, 99) < 30);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_dir_controller.md
# key_dir_controller

Sequences decoded PS/2 scan-code bytes into snake-game control. Sits between the PS/2 byte receiver (bytes already synchronized into the system clock domain) and the snake movement engine. Tracks E0/F0 prefix state and maps make codes to direction, pause and restart commands. Buffers turns in a small queue that the engine drains once per game step, rejecting reversals and repeats.

## Interface
- `QUEUE_DEPTH`, 2: turn queue entries (power of two, 2..8)
- `PREFIX_TIMEOUT`, 1_000_000: clk cycles a prefix state may wait for its next byte
- `clk` input 1: system clock, all logic on rising edge
- `reset` input 1: synchronous, active-high
- `key_valid` input 1: one-cycle strobe, `key_code` valid
- `key_code` input 8: received scan-code byte
- `step` input 1: one-cycle strobe from engine; consume next queued turn
- `dir` output 2: current heading; 00 up, 01 right, 10 down, 11 left
- `paused` output 1: pause level
- `restart` output 1: one-cycle restart pulse
- `queue_count` output $clog2(QUEUE_DEPTH)+1: entries pending

## Operation
- Prefix FSM states and transitions:
  - IDLE: E0 -> EXT; F0 -> BRK; otherwise decode the byte as a non-extended make code and stay in IDLE.
  - EXT: F0 -> EXT_BRK; otherwise decode the byte as an extended make code and go to IDLE.
  - BRK: any byte -> IDLE, with the byte discarded.
  - EXT_BRK: any byte -> IDLE, with the byte discarded.
- Prefix timeout: a counter clears on entry to a prefix state. If it reaches PREFIX_TIMEOUT-1 with no `key_valid`, the FSM goes to IDLE.
- Extended direction make codes: 75 up, 74 right, 72 down, 6B left.
- Non-extended direction make codes: 1D up, 23 right, 1B down, 1C left.
- Other make codes:
  - 29 (space, non-extended): toggles `paused`.
  - 76 (Esc, non-extended): fires `restart`.
  - All other codes are ignored.
- Turn filter:
  - Reference direction R is the queue tail, or `dir` if the queue is empty.
  - A new direction D is pushed only if D != R and D != R^2'b10.
  - A push while the queue is full drops D.
- Pop: on `step` with the queue non-empty and `paused`=0, the head loads into `dir`. Otherwise `dir` holds.
- `step` while `paused`=1 has no effect.
- Restart:
  - The queue clears, `dir` is set to 01 and `paused` to 0.
  - The FSM goes to IDLE.
  - `restart`=1 for exactly one cycle.
- Outputs on reset:
  - `dir`=01, `paused`=0, `restart`=0, `queue_count`=0.
  - FSM in IDLE, timeout counter 0.

## Timing
- `key_valid` in cycle N: FSM state, queue push, `paused` and `restart` are all updated at the edge ending N, visible in N+1.
- `step` in cycle N: `dir` and `queue_count` are visible in N+1.
- Push and pop in the same cycle:
  - The pop uses the head as it was before the edge.
  - The filter reference is the pre-edge tail. If the queue is empty, it is the pre-edge `dir`.
  - With the queue full, a simultaneous push and pop both succeed and the count is unchanged.
- Restart together with `step` or a push: restart wins; the queue ends empty.
- `reset` overrides everything in the same edge, including a mid-prefix sequence.
- Back-to-back `key_valid` on consecutive cycles must be accepted.
- Queue pointers wrap modulo QUEUE_DEPTH.

## Structure
- Package `snake_pkg` holds:
  - direction encodings DIR_UP/RIGHT/DOWN/LEFT and a 2-bit `dir_t`;
  - scan-code constants (E0, F0, arrows, WASD, space, Esc);
  - the prefix FSM state enum.
- Sub-module `turn_fifo`:
  - Parameterised depth, 2-bit synchronous FIFO.
  - Ports: push, pop, clear, din, head, tail, count, full, empty.
  - Push and pop may occur in the same cycle.
- `key_dir_controller` holds the prefix FSM, timeout counter, decode, filter, pause/restart logic and the `dir` register.

## Test plan
- Reset, then bytes E0 75, then `step`: `queue_count` goes 0->1, and `dir` becomes 00 one cycle after `step`.
- From `dir`=01, bytes 1C (left, a reversal) then 23 (right, a repeat): neither is pushed; `queue_count` stays 0.
- QUEUE_DEPTH=2, `dir`=01: keys up, left, down with no `step`:
  - up and left are queued, down is dropped because the queue is full;
  - two `step`s give `dir` 00 then 11.
- Bytes F0 1D: no push. Bytes E0 F0 75: no push. E0 alone then PREFIX_TIMEOUT idle cycles, then 1D: up is pushed, since the FSM returned to IDLE.
- Byte 29 then `step` with one entry queued: `paused`=1 and `dir` is unchanged. A second 29 sets `paused`=0 and the next `step` pops.
- Byte 76 in the same cycle as `step` with two entries queued:
  - `restart` pulses for one cycle;
  - `queue_count`=0, `dir`=01, `paused`=0.
